// File: rtl/mips_exec_core.sv
// mips_exec_core: single-cycle MIPS execute/memory slice.
// Control decode, 32-bit ALU with operand muxing, and a word-addressed
// data memory. Addresses >= PERIPH_BASE go to the peripheral strobes.
// Optional feature macro: ALU_OVF_TRAP_EN (drives alu_overflow when defined,
// otherwise alu_overflow is tied low and the overflow logic is absent).
module mips_exec_core #(
  parameter int          DMEM_WORDS  = 256,
  parameter logic [31:0] PERIPH_BASE = 32'h40000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        pc_super,
  input  logic        irq,
  input  logic        exc,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [1:0]  pc_src,
  output logic [1:0]  reg_dst,
  output logic        reg_wr,
  output logic [1:0]  mem_to_reg,
  output logic [31:0] ext_imm,
  output logic [31:0] alu_out,
  output logic        alu_overflow,
  output logic        undef,
  output logic        periph_rd,
  output logic        periph_wr,
  output logic [31:0] mem_rdata
);

  localparam int IDX_W = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  localparam logic [5:0] F_ADD  = 6'b000000, F_SUB  = 6'b000001;
  localparam logic [5:0] F_AND  = 6'b011000, F_OR   = 6'b011110;
  localparam logic [5:0] F_XOR  = 6'b010110, F_NOR  = 6'b010001;
  localparam logic [5:0] F_PASS = 6'b011010;
  localparam logic [5:0] F_SLL  = 6'b100000, F_SRL  = 6'b100001;
  localparam logic [5:0] F_SRA  = 6'b100011;
  localparam logic [5:0] F_EQ   = 6'b110011, F_NEQ  = 6'b110001;
  localparam logic [5:0] F_LT   = 6'b110101, F_LEZ  = 6'b111101;
  localparam logic [5:0] F_LTZ  = 6'b111011, F_GTZ  = 6'b111111;

  logic [5:0]  opcode_s, funct_s;
  logic [1:0]  pc_src_dec_s, reg_dst_dec_s, mem_to_reg_dec_s;
  logic        reg_wr_dec_s, mem_rd_dec_s, mem_wr_dec_s, undef_dec_s;
  logic [5:0]  alu_fun_s;
  logic        sign_s, ext_op_s, src_imm_s, shamt_sel_s, lui_s;
  logic        trap_s, mem_rd_s, mem_wr_s;
  logic [31:0] a_s, b_s, imm_s, sum_s, diff_s, alu_res_s;
  logic [29:0] word_idx_s;
  logic [IDX_W-1:0] idx_s;
  logic        mem_sel_s, in_range_s;
  logic [31:0] mem_q [DMEM_WORDS];
  logic        unused_rs_field_s;

  assign opcode_s = instr[31:26];
  assign funct_s  = instr[5:0];
  // The rs register number is consumed by the register file, not here.
  assign unused_rs_field_s = ^instr[25:21];

  // Instruction decode: control fields, ALU function and operand selects.
  always_comb begin
    pc_src_dec_s     = 2'b00;
    reg_dst_dec_s    = 2'b00;
    reg_wr_dec_s     = 1'b0;
    mem_to_reg_dec_s = 2'b00;
    mem_rd_dec_s     = 1'b0;
    mem_wr_dec_s     = 1'b0;
    undef_dec_s      = 1'b0;
    alu_fun_s        = F_ADD;
    sign_s           = 1'b1;
    ext_op_s         = 1'b1;
    src_imm_s        = 1'b0;
    shamt_sel_s      = 1'b0;
    lui_s            = 1'b0;
    case (opcode_s)
      6'h00: begin
        reg_wr_dec_s = 1'b1;
        case (funct_s)
          6'h20: alu_fun_s = F_ADD;
          6'h21: begin alu_fun_s = F_ADD; sign_s = 1'b0; end
          6'h22: alu_fun_s = F_SUB;
          6'h23: begin alu_fun_s = F_SUB; sign_s = 1'b0; end
          6'h24: alu_fun_s = F_AND;
          6'h25: alu_fun_s = F_OR;
          6'h26: alu_fun_s = F_XOR;
          6'h27: alu_fun_s = F_NOR;
          6'h2a: alu_fun_s = F_LT;
          6'h2b: begin alu_fun_s = F_LT; sign_s = 1'b0; end
          6'h00: begin alu_fun_s = F_SLL; shamt_sel_s = 1'b1; end
          6'h02: begin alu_fun_s = F_SRL; shamt_sel_s = 1'b1; end
          6'h03: begin alu_fun_s = F_SRA; shamt_sel_s = 1'b1; end
          6'h08: begin pc_src_dec_s = 2'b11; reg_wr_dec_s = 1'b0; end
          6'h09: begin pc_src_dec_s = 2'b11; mem_to_reg_dec_s = 2'b10; end
          default: begin undef_dec_s = 1'b1; reg_wr_dec_s = 1'b0; end
        endcase
      end
      6'h08: begin src_imm_s = 1'b1; reg_dst_dec_s = 2'b01; reg_wr_dec_s = 1'b1; end
      6'h09: begin src_imm_s = 1'b1; reg_dst_dec_s = 2'b01; reg_wr_dec_s = 1'b1; sign_s = 1'b0; end
      6'h0c: begin src_imm_s = 1'b1; reg_dst_dec_s = 2'b01; reg_wr_dec_s = 1'b1; ext_op_s = 1'b0; alu_fun_s = F_AND; end
      6'h0a: begin src_imm_s = 1'b1; reg_dst_dec_s = 2'b01; reg_wr_dec_s = 1'b1; alu_fun_s = F_LT; end
      6'h0b: begin src_imm_s = 1'b1; reg_dst_dec_s = 2'b01; reg_wr_dec_s = 1'b1; alu_fun_s = F_LT; sign_s = 1'b0; end
      6'h0f: begin src_imm_s = 1'b1; reg_dst_dec_s = 2'b01; reg_wr_dec_s = 1'b1; lui_s = 1'b1; end
      6'h23: begin
        src_imm_s = 1'b1; reg_dst_dec_s = 2'b01; reg_wr_dec_s = 1'b1;
        mem_to_reg_dec_s = 2'b01; mem_rd_dec_s = 1'b1;
      end
      6'h2b: begin src_imm_s = 1'b1; mem_wr_dec_s = 1'b1; end
      6'h04: begin pc_src_dec_s = 2'b01; alu_fun_s = F_EQ; end
      6'h05: begin pc_src_dec_s = 2'b01; alu_fun_s = F_NEQ; end
      6'h06: begin pc_src_dec_s = 2'b01; alu_fun_s = F_LEZ; end
      6'h07: begin pc_src_dec_s = 2'b01; alu_fun_s = F_GTZ; end
      6'h01: begin
        if (instr[20:16] == 5'd0) begin
          pc_src_dec_s = 2'b01;
          alu_fun_s    = F_LTZ;
        end else begin
          undef_dec_s  = 1'b1;
        end
      end
      6'h02: pc_src_dec_s = 2'b10;
      6'h03: begin
        pc_src_dec_s = 2'b10; reg_dst_dec_s = 2'b10;
        reg_wr_dec_s = 1'b1;  mem_to_reg_dec_s = 2'b10;
      end
      default: undef_dec_s = 1'b1;
    endcase
  end

  // An exception, or an interrupt outside kernel mode, overrides decode.
  assign trap_s     = exc | (irq & ~pc_super);
  assign pc_src     = trap_s ? 2'b00 : pc_src_dec_s;
  assign reg_dst    = trap_s ? 2'b11 : reg_dst_dec_s;
  assign reg_wr     = trap_s ? 1'b1  : reg_wr_dec_s;
  assign mem_to_reg = trap_s ? 2'b10 : mem_to_reg_dec_s;
  assign undef      = trap_s ? 1'b0  : undef_dec_s;
  assign mem_rd_s   = ~trap_s & mem_rd_dec_s;
  assign mem_wr_s   = ~trap_s & mem_wr_dec_s;

  // Operand muxing.
  assign ext_imm = ext_op_s ? {{16{instr[15]}}, instr[15:0]} : {16'h0000, instr[15:0]};
  assign imm_s   = lui_s ? {instr[15:0], 16'h0000} : ext_imm;
  assign a_s     = shamt_sel_s ? {27'd0, instr[10:6]} : rs_data;
  assign b_s     = src_imm_s ? imm_s : rt_data;
  assign sum_s   = a_s + b_s;
  assign diff_s  = a_s - b_s;

  // ALU result selection by function code.
  always_comb begin
    alu_res_s = 32'd0;
    case (alu_fun_s)
      F_ADD:  alu_res_s = sum_s;
      F_SUB:  alu_res_s = diff_s;
      F_AND:  alu_res_s = a_s & b_s;
      F_OR:   alu_res_s = a_s | b_s;
      F_XOR:  alu_res_s = a_s ^ b_s;
      F_NOR:  alu_res_s = ~(a_s | b_s);
      F_PASS: alu_res_s = a_s;
      F_SLL:  alu_res_s = b_s << a_s[4:0];
      F_SRL:  alu_res_s = b_s >> a_s[4:0];
      F_SRA:  alu_res_s = $signed(b_s) >>> a_s[4:0];
      F_EQ:   alu_res_s = {31'd0, a_s == b_s};
      F_NEQ:  alu_res_s = {31'd0, a_s != b_s};
      F_LT:   alu_res_s = {31'd0, sign_s ? ($signed(a_s) < $signed(b_s)) : (a_s < b_s)};
      F_LEZ:  alu_res_s = {31'd0, a_s[31] | (a_s == 32'd0)};
      F_LTZ:  alu_res_s = {31'd0, a_s[31]};
      F_GTZ:  alu_res_s = {31'd0, ~a_s[31] & (a_s != 32'd0)};
      default: alu_res_s = 32'd0;
    endcase
  end
  assign alu_out = alu_res_s;

`ifdef ALU_OVF_TRAP_EN
  assign alu_overflow = sign_s & (
      ((alu_fun_s == F_ADD) & (a_s[31] == b_s[31]) & (sum_s[31]  != a_s[31])) |
      ((alu_fun_s == F_SUB) & (a_s[31] != b_s[31]) & (diff_s[31] != a_s[31])));
`else
  assign alu_overflow = 1'b0;
`endif

  // Address steering between data memory and peripherals.
  assign word_idx_s = alu_out[31:2];
  assign idx_s      = word_idx_s[IDX_W-1:0];
  assign mem_sel_s  = (alu_out < PERIPH_BASE);
  assign in_range_s = ({2'b00, word_idx_s} < 32'(DMEM_WORDS));
  assign periph_rd  = mem_rd_s & ~mem_sel_s;
  assign periph_wr  = mem_wr_s & ~mem_sel_s;
  assign mem_rdata  = (mem_rd_s & mem_sel_s & in_range_s) ? mem_q[idx_s] : 32'd0;

  // Data memory array: cleared by reset, written on the rising clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DMEM_WORDS; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (mem_wr_s & mem_sel_s & in_range_s) begin
      mem_q[idx_s] <= rt_data;
    end
  end

endmodule

// File: tb/tb_mips_exec_core.sv
// Scoreboard bench for mips_exec_core: a driver issues one instruction per
// cycle and queues the expected response from a reference model; a monitor
// on the falling edge pops and compares.
module tb_mips_exec_core;

  logic        clk = 1'b0;
  logic        reset, pc_super, irq, exc;
  logic [31:0] instr, rs_data, rt_data;
  logic [1:0]  pc_src, reg_dst, mem_to_reg;
  logic        reg_wr, alu_overflow, undef, periph_rd, periph_wr;
  logic [31:0] ext_imm, alu_out, mem_rdata;

  mips_exec_core dut (
    .clk(clk), .reset(reset), .instr(instr), .pc_super(pc_super),
    .irq(irq), .exc(exc), .rs_data(rs_data), .rt_data(rt_data),
    .pc_src(pc_src), .reg_dst(reg_dst), .reg_wr(reg_wr),
    .mem_to_reg(mem_to_reg), .ext_imm(ext_imm), .alu_out(alu_out),
    .alu_overflow(alu_overflow), .undef(undef), .periph_rd(periph_rd),
    .periph_wr(periph_wr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  pc_src, reg_dst, mem_to_reg;
    logic        reg_wr, chk_alu, ovf, undef, prd, pwr, mwe;
    logic [31:0] ext_imm, alu, rdata;
    int          midx;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem_m [256];
  int          n_total = 0;
  int          n_pass  = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp_v);
  endtask

  function automatic logic ovf_of(logic [31:0] a, logic [31:0] b, logic is_sub);
    longint s;
    s = is_sub ? (longint'($signed(a)) - longint'($signed(b)))
               : (longint'($signed(a)) + longint'($signed(b)));
`ifdef ALU_OVF_TRAP_EN
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: what the instruction should do, from MIPS semantics.
  function automatic exp_t model(string nm, logic [31:0] ins, logic [31:0] rs,
                                 logic [31:0] rt, logic irq_v, logic exc_v, logic sup_v);
    exp_t e;
    logic [5:0]  op, fn;
    logic [4:0]  sh;
    logic [31:0] sx, zx, addr;
    logic        rd, wr, periph;
    op = ins[31:26]; fn = ins[5:0]; sh = ins[10:6];
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'h0000, ins[15:0]};
    e.name = nm; e.pc_src = 2'd0; e.reg_dst = 2'd0; e.mem_to_reg = 2'd0;
    e.reg_wr = 1'b0; e.chk_alu = 1'b1; e.ovf = 1'b0; e.undef = 1'b0;
    e.alu = 32'd0; e.ext_imm = (op == 6'h0c) ? zx : sx;
    rd = 1'b0; wr = 1'b0;
    case (op)
      6'h00: begin
        e.reg_wr = 1'b1;
        case (fn)
          6'h20: begin e.alu = rs + rt; e.ovf = ovf_of(rs, rt, 1'b0); end
          6'h21: e.alu = rs + rt;
          6'h22: begin e.alu = rs - rt; e.ovf = ovf_of(rs, rt, 1'b1); end
          6'h23: e.alu = rs - rt;
          6'h24: e.alu = rs & rt;
          6'h25: e.alu = rs | rt;
          6'h26: e.alu = rs ^ rt;
          6'h27: e.alu = ~(rs | rt);
          6'h2a: e.alu = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
          6'h2b: e.alu = (rs < rt) ? 32'd1 : 32'd0;
          6'h00: e.alu = rt << sh;
          6'h02: e.alu = rt >> sh;
          6'h03: e.alu = $signed(rt) >>> sh;
          6'h08: begin e.pc_src = 2'd3; e.reg_wr = 1'b0; e.chk_alu = 1'b0; end
          6'h09: begin e.pc_src = 2'd3; e.mem_to_reg = 2'd2; e.chk_alu = 1'b0; end
          default: begin e.undef = 1'b1; e.reg_wr = 1'b0; e.chk_alu = 1'b0; end
        endcase
      end
      6'h08: begin e.alu = rs + sx; e.ovf = ovf_of(rs, sx, 1'b0); e.reg_dst = 2'd1; e.reg_wr = 1'b1; end
      6'h09: begin e.alu = rs + sx; e.reg_dst = 2'd1; e.reg_wr = 1'b1; end
      6'h0c: begin e.alu = rs & zx; e.reg_dst = 2'd1; e.reg_wr = 1'b1; end
      6'h0a: begin e.alu = ($signed(rs) < $signed(sx)) ? 32'd1 : 32'd0; e.reg_dst = 2'd1; e.reg_wr = 1'b1; end
      6'h0b: begin e.alu = (rs < sx) ? 32'd1 : 32'd0; e.reg_dst = 2'd1; e.reg_wr = 1'b1; end
      6'h0f: begin e.alu = rs + (zx << 16); e.reg_dst = 2'd1; e.reg_wr = 1'b1; end
      6'h23: begin
        e.alu = rs + sx; e.ovf = ovf_of(rs, sx, 1'b0);
        e.reg_dst = 2'd1; e.reg_wr = 1'b1; e.mem_to_reg = 2'd1; rd = 1'b1;
      end
      6'h2b: begin e.alu = rs + sx; e.ovf = ovf_of(rs, sx, 1'b0); wr = 1'b1; end
      6'h04: begin e.pc_src = 2'd1; e.alu = (rs == rt) ? 32'd1 : 32'd0; end
      6'h05: begin e.pc_src = 2'd1; e.alu = (rs != rt) ? 32'd1 : 32'd0; end
      6'h06: begin e.pc_src = 2'd1; e.alu = ($signed(rs) <= 0) ? 32'd1 : 32'd0; end
      6'h07: begin e.pc_src = 2'd1; e.alu = ($signed(rs) > 0) ? 32'd1 : 32'd0; end
      6'h01: begin
        if (ins[20:16] == 5'd0) begin
          e.pc_src = 2'd1; e.alu = ($signed(rs) < 0) ? 32'd1 : 32'd0;
        end else begin
          e.undef = 1'b1; e.chk_alu = 1'b0;
        end
      end
      6'h02: begin e.pc_src = 2'd2; e.chk_alu = 1'b0; end
      6'h03: begin e.pc_src = 2'd2; e.reg_dst = 2'd2; e.reg_wr = 1'b1; e.mem_to_reg = 2'd2; e.chk_alu = 1'b0; end
      default: begin e.undef = 1'b1; e.chk_alu = 1'b0; end
    endcase
    if (exc_v || (irq_v && !sup_v)) begin
      e.reg_dst = 2'd3; e.reg_wr = 1'b1; e.mem_to_reg = 2'd2; e.pc_src = 2'd0;
      e.undef = 1'b0; rd = 1'b0; wr = 1'b0;
    end
    addr   = e.alu;
    periph = (addr >= 32'h40000000);
    e.prd  = rd && periph;
    e.pwr  = wr && periph;
    e.midx = int'(addr >> 2);
    e.mwe  = wr && !periph && (e.midx < 256);
    e.rdata = (rd && !periph && (e.midx < 256)) ? mem_m[e.midx] : 32'd0;
    return e;
  endfunction

  task automatic issue(string nm, logic [31:0] ins, logic [31:0] rs, logic [31:0] rt,
                       logic irq_v = 1'b0, logic exc_v = 1'b0, logic sup_v = 1'b0,
                       logic rst_v = 1'b0);
    exp_t e;
    @(posedge clk); #1;
    reset = rst_v;
    if (rst_v) begin
      for (int i = 0; i < 256; i++) mem_m[i] = 32'd0;
    end
    instr = ins; rs_data = rs; rt_data = rt;
    irq = irq_v; exc = exc_v; pc_super = sup_v;
    e = model(nm, ins, rs, rt, irq_v, exc_v, sup_v);
    sb_q.push_back(e);
    if (e.mwe && !rst_v) mem_m[e.midx] = rt;
  endtask

  function automatic logic [31:0] mk_r(logic [5:0] fn, logic [4:0] rt, logic [4:0] rd, logic [4:0] sh);
    return {6'h00, 5'd1, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] mk_i(logic [5:0] op, logic [4:0] rt, logic [15:0] imm);
    return {op, 5'd2, rt, imm};
  endfunction

  // Monitor: compare every presented response against the queued expectation.
  exp_t mon_e;
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk({mon_e.name, ".pc_src"},     {30'd0, pc_src},     {30'd0, mon_e.pc_src});
      chk({mon_e.name, ".reg_dst"},    {30'd0, reg_dst},    {30'd0, mon_e.reg_dst});
      chk({mon_e.name, ".reg_wr"},     {31'd0, reg_wr},     {31'd0, mon_e.reg_wr});
      chk({mon_e.name, ".mem_to_reg"}, {30'd0, mem_to_reg}, {30'd0, mon_e.mem_to_reg});
      chk({mon_e.name, ".ext_imm"},    ext_imm,             mon_e.ext_imm);
      chk({mon_e.name, ".undef"},      {31'd0, undef},      {31'd0, mon_e.undef});
      chk({mon_e.name, ".periph_rd"},  {31'd0, periph_rd},  {31'd0, mon_e.prd});
      chk({mon_e.name, ".periph_wr"},  {31'd0, periph_wr},  {31'd0, mon_e.pwr});
      chk({mon_e.name, ".mem_rdata"},  mem_rdata,           mon_e.rdata);
      if (mon_e.chk_alu) begin
        chk({mon_e.name, ".alu_out"},      alu_out,                mon_e.alu);
        chk({mon_e.name, ".alu_overflow"}, {31'd0, alu_overflow}, {31'd0, mon_e.ovf});
      end
    end
  end

  logic [5:0] r_fn [15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                            6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h08, 6'h09};
  logic [5:0] i_op [15] = '{6'h08, 6'h09, 6'h0c, 6'h0a, 6'h0b, 6'h0f, 6'h23, 6'h2b,
                            6'h04, 6'h05, 6'h06, 6'h07, 6'h01, 6'h02, 6'h03};

  initial begin
    logic [31:0] ins, rs, rt;
    logic [5:0]  op;
    reset = 1'b1; instr = 32'd0; rs_data = 32'd0; rt_data = 32'd0;
    irq = 1'b0; exc = 1'b0; pc_super = 1'b0;
    for (int i = 0; i < 256; i++) mem_m[i] = 32'd0;

    // Reset state: a load during reset reads a cleared memory.
    issue("rst_lw", mk_i(6'h23, 5'd3, 16'h0010), 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    issue("addi_neg", 32'h2008FFFB, 32'd0, 32'd0);
    issue("sll4", mk_r(6'h00, 5'd9, 5'd8, 5'd4), 32'd0, 32'h0000000F);
    issue("sra4", mk_r(6'h03, 5'd9, 5'd8, 5'd4), 32'd0, 32'h80000000);
    issue("add_ovf", mk_r(6'h20, 5'd9, 5'd8, 5'd0), 32'h7FFFFFFF, 32'd1);
    issue("addu_noovf", mk_r(6'h21, 5'd9, 5'd8, 5'd0), 32'h7FFFFFFF, 32'd1);
    issue("sub_ovf", mk_r(6'h22, 5'd9, 5'd8, 5'd0), 32'h80000000, 32'd1);
    issue("sw10", mk_i(6'h2b, 5'd3, 16'h0010), 32'd0, 32'hDEADBEEF);
    issue("lw10", mk_i(6'h23, 5'd3, 16'h0010), 32'd0, 32'd0);
    issue("lw10_rst", mk_i(6'h23, 5'd3, 16'h0010), 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    issue("lw10_after", mk_i(6'h23, 5'd3, 16'h0010), 32'd0, 32'd0);
    issue("sw_periph", mk_i(6'h2b, 5'd3, 16'h0000), 32'h40000000, 32'h12345678);
    issue("lw_periph", mk_i(6'h23, 5'd3, 16'h0000), 32'h40000000, 32'd0);
    issue("lw0_unchg", mk_i(6'h23, 5'd3, 16'h0000), 32'd0, 32'd0);
    issue("sw_oor", mk_i(6'h2b, 5'd3, 16'h0400), 32'd0, 32'hCAFEF00D);
    issue("lw_oor", mk_i(6'h23, 5'd3, 16'h0400), 32'd0, 32'd0);
    issue("lw_last", mk_i(6'h23, 5'd3, 16'h03FC), 32'd0, 32'd0);
    issue("andi_zx", mk_i(6'h0c, 5'd3, 16'h8001), 32'hFFFFFFFF, 32'd0);
    issue("lui", mk_i(6'h0f, 5'd3, 16'hABCD), 32'd0, 32'd0);
    issue("beq_eq", mk_i(6'h04, 5'd3, 16'h0004), 32'h55AA55AA, 32'h55AA55AA);
    issue("bltz_pos", {6'h01, 5'd2, 5'd0, 16'h0004}, 32'd1, 32'd0);
    issue("jal", {6'h03, 26'h0000100}, 32'd0, 32'd0);
    issue("irq_sw", mk_i(6'h2b, 5'd3, 16'h0020), 32'd0, 32'h11111111, 1'b1, 1'b0, 1'b0);
    issue("lw20_none", mk_i(6'h23, 5'd3, 16'h0020), 32'd0, 32'd0);
    issue("irq_sup_sw", mk_i(6'h2b, 5'd3, 16'h0020), 32'd0, 32'h22222222, 1'b1, 1'b0, 1'b1);
    issue("lw20_done", mk_i(6'h23, 5'd3, 16'h0020), 32'd0, 32'd0);
    issue("exc_sup", mk_i(6'h23, 5'd3, 16'h0020), 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    issue("undef3f", {6'h3F, 26'h0}, 32'd0, 32'd0);
    issue("undef_fn", mk_r(6'h3F, 5'd9, 5'd8, 5'd0), 32'd0, 32'd0);

    // Randomized instruction stream.
    for (int n = 0; n < 400; n++) begin
      rs = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) - 32'd4 : $urandom;
      rt = ($urandom_range(0, 3) == 0) ? rs : $urandom;
      if ($urandom_range(0, 19) == 0) begin
        ins = {6'($urandom_range(16, 63)), 26'($urandom)};
      end else if ($urandom_range(0, 1) == 0) begin
        ins = {6'h00, 20'($urandom), r_fn[$urandom_range(0, 14)]};
      end else begin
        op  = i_op[$urandom_range(0, 14)];
        ins = {op, 26'($urandom)};
        if (op == 6'h01) ins[20:16] = ($urandom_range(0, 4) == 0) ? 5'd1 : 5'd0;
        if (op == 6'h0f) rs = 32'd0;
        if (op == 6'h23 || op == 6'h2b) begin
          ins[15:0] = 16'($urandom_range(0, 255));
          rs = ($urandom_range(0, 9) == 0) ? 32'h40000000 + 32'($urandom_range(0, 64))
                                           : 32'($urandom_range(0, 1100));
        end
      end
      issue($sformatf("rnd%0d", n), ins, rs, rt,
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 1)));
    end

    // Let the monitor drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    chk("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
